lfsr_prbs_gen: RTL and testbench
================================

// Module: lfsr_prbs_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random bit generator; successor to the fixed 4-bit LFSR.
//  Adds generic width/taps, seed load with all-zero protection, and burst or continuous modes.
//  Has a start/stop/done handshake and a parallel state view.
//  Feeds scramblers and PRBS test sources; output is one bit per clock, qualified by valid.
// PARAMETERS
//  WIDTH  4        LFSR register width (>=2)
//  TAPS   4'b1100  feedback mask; bit i set => state[i] in XOR (default x^4+x^3+1, maximal)
//  INIT   4'b0001  state after reset (must be nonzero)
//  CNT_W  8        width of burst_len and internal bit counter
// PORTS
//  clock      in   1      single clock; all logic on rising edge
//  reset      in   1      synchronous, active-high
//  seed       in   WIDTH  seed value, sampled on load
//  load       in   1      load seed (honoured in IDLE only)
//  start      in   1      begin generation (honoured in IDLE only)
//  stop       in   1      abort generation (honoured in RUN only)
//  mode       in   1      0 = burst of burst_len bits, 1 = continuous; latched on start
//  burst_len  in   CNT_W  bits per burst; latched on start
//  OUT        out  1      generated bit, registered
//  valid      out  1      OUT qualifier, registered
//  done       out  1      1-cycle pulse at burst completion
//  busy       out  1      high while FSM in RUN
//  seed_err   out  1      last load used the all-zero seed
//  state      out  WIDTH  current LFSR contents
// BEHAVIOUR
//  Reset values: state=INIT, OUT=0, valid=0, done=0, busy=0, seed_err=0, FSM=IDLE.
//  Reset is honoured in any state; a burst in flight is aborted with no done pulse.
//  Feedback: fb = ^(state & TAPS). Shift: state <= {state[WIDTH-2:0], fb}; OUT <= state[WIDTH-1].
//  FSM IDLE:
//   - load: state <= seed; seed_err <= 0.
//     If seed == 0: state <= 1 and seed_err <= 1.
//   - start: latch mode and burst_len, clear counter.
//     If mode=0 and burst_len=0: stay IDLE, pulse done next cycle, no valid.
//     Otherwise go to RUN (busy=1 from next cycle).
//   - load and start in the same cycle: load applies first; the run starts from the new seed.
//   - Shift register holds; valid=0.
//  FSM RUN, each edge unless stop:
//   - shift once, OUT <= old MSB, valid <= 1, counter++.
//   - Burst mode: on the edge that emits bit burst_len, go to IDLE.
//     done=1 during the same cycle as the last valid=1.
//   - Continuous mode: never self-terminates; the counter wraps silently.
//  RUN with stop: no shift that edge, valid <= 0, go to IDLE, done stays 0.
//   - stop wins over a simultaneous last burst bit.
//  In RUN, load and start are ignored. In IDLE, stop is ignored.
//  Latency: start registered at edge E0 gives valid=1 after E1..EL; valid=0 after E(L+1).
//  The state register retains its value across runs; a new start continues the sequence.
//  Maximal TAPS give period 2^WIDTH-1; the all-zero state is unreachable except via a bad TAPS mask.
// TESTING
//  1) Reset, load seed=4'b1001, start mode=0 burst_len=8:
//     -> OUT 1,0,0,1,1,0,1,0 with valid=1 for exactly 8 cycles; done=1 on the 8th; state=4'b1111 after.
//  2) Load 4'b1001, start mode=1, run 15 bits:
//     -> state returns to 4'b1001 after bit 15; sequence repeats with period 15.
//  3) Load seed=0 -> state=4'b0001, seed_err=1; load 4'b0110 -> seed_err=0.
//  4) Burst_len=8, stop asserted on the 3rd RUN cycle:
//     -> 2 valid bits, then valid=0, busy=0, done never pulses.
//  5) Reset asserted mid-burst -> next cycle all outputs at reset values, state=INIT.
//     Start with burst_len=0 -> done pulse, valid stays 0.
//  6) Load+start in the same cycle with seed=4'b1001 -> first OUT=1.
//     Load/start pulsed during RUN -> no effect on sequence or count.

Source files
------------

// File: rtl/lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_gen
//
// Purpose
//   Fibonacci LFSR pseudo-random bit generator. It produces one bit per clock,
//   and valid_o qualifies each bit. It is used as the bit source for
//   scramblers and PRBS test generators.
//   - Width and feedback taps are set by parameters.
//   - A seed can be loaded. An all-zero seed is replaced by 1 and flagged.
//   - Generation runs either as a fixed-length burst or continuously.
//   - A start/stop/done handshake controls it, and the raw LFSR contents are
//     visible on state_o.
//
// Parameters
//   WIDTH  LFSR register width (>= 2)
//   TAPS   feedback mask; bit i set => state[i] takes part in the XOR
//   INIT   state after reset (must be nonzero)
//   CNT_W  width of burst_len_i and of the internal bit counter
//
// Ports
//   clk_i        single clock, all logic on the rising edge
//   rst_i        synchronous, active-high reset
//   seed_i       seed value, sampled when load_i is honoured
//   load_i       load seed (honoured in IDLE only)
//   start_i      begin generation (honoured in IDLE only)
//   stop_i       abort generation (honoured in RUN only)
//   mode_i       0 = burst of burst_len_i bits, 1 = continuous; latched on start
//   burst_len_i  bits per burst; latched on start
//   out_o        generated bit (registered)
//   valid_o      out_o qualifier (registered)
//   done_o       one-cycle pulse, coincident with the last valid bit of a burst
//   busy_o       high while the FSM is in RUN (registered)
//   seed_err_o   last honoured load used the all-zero seed
//   state_o      current LFSR contents
// -----------------------------------------------------------------------------
module lfsr_prbs_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] INIT  = 4'b0001,
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             load_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic             out_o,
  output logic             valid_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             seed_err_o,
  output logic [WIDTH-1:0] state_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

  // A bad seed is replaced by the smallest nonzero state. This keeps the
  // LFSR out of the all-zero lock-up state.
  localparam logic [WIDTH-1:0] SEED_FIX = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] ST_ZERO  = {WIDTH{1'b0}};

  // XOR-reduce the tapped bits. This is the bit shifted in at the LSB.
  function automatic logic lfsr_feedback(input logic [WIDTH-1:0] s);
    return ^(s & TAPS);
  endfunction

  // Advance the LFSR by one step.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], lfsr_feedback(s)};
  endfunction

  fsm_e             fsm_q,      fsm_d;
  logic [WIDTH-1:0] lfsr_q,     lfsr_d;
  logic             out_q,      out_d;
  logic             valid_q,    valid_d;
  logic             done_q,     done_d;
  logic             busy_q,     busy_d;
  logic             seed_err_q, seed_err_d;
  logic             mode_q,     mode_d;
  logic [CNT_W-1:0] len_q,      len_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state and output decode for the IDLE/RUN controller and the datapath.
  always_comb begin
    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    seed_err_d = seed_err_q;
    mode_d     = mode_q;
    len_d      = len_q;
    cnt_d      = cnt_q;

    case (fsm_q)
      ST_IDLE: begin
        // The load is decoded before the start. When both arrive together,
        // the new seed is in place before the first RUN shift.
        if (load_i) begin
          if (seed_i == ST_ZERO) begin
            lfsr_d     = SEED_FIX;
            seed_err_d = 1'b1;
          end else begin
            lfsr_d     = seed_i;
            seed_err_d = 1'b0;
          end
        end else begin
          lfsr_d = lfsr_q;
        end

        if (start_i) begin
          mode_d = mode_i;
          len_d  = burst_len_i;
          cnt_d  = CNT_ZERO;
          // An empty burst completes at once. done pulses, nothing is emitted,
          // and the FSM stays in IDLE.
          if (!mode_i && (burst_len_i == CNT_ZERO)) begin
            done_d = 1'b1;
            fsm_d  = ST_IDLE;
          end else begin
            fsm_d = ST_RUN;
          end
        end else begin
          fsm_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // stop has priority over everything, including the last burst bit.
        if (stop_i) begin
          fsm_d   = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          lfsr_d  = lfsr_step(lfsr_q);
          out_d   = lfsr_q[WIDTH-1];
          valid_d = 1'b1;
          // In continuous mode the counter wraps. Its value is never used there.
          cnt_d   = cnt_inc_s;
          if (!mode_q && (cnt_inc_s == len_q)) begin
            fsm_d  = ST_IDLE;
            done_d = 1'b1;
          end else begin
            fsm_d = ST_RUN;
          end
        end
      end

      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    busy_d = (fsm_d == ST_RUN);
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q      <= ST_IDLE;
      lfsr_q     <= INIT;
      out_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      seed_err_q <= 1'b0;
      mode_q     <= 1'b0;
      len_q      <= CNT_ZERO;
      cnt_q      <= CNT_ZERO;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      seed_err_q <= seed_err_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_o      = out_q;
  assign valid_o    = valid_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign seed_err_o = seed_err_q;
  assign state_o    = lfsr_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_gen
// Directed and randomised bench for lfsr_prbs_gen with default parameters.
// The expected bit stream comes from a polynomial model: the next state is the
// state doubled, plus the parity of the tapped bits.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_gen;

  localparam logic [3:0] M_TAPS = 4'b1100;
  localparam logic [3:0] M_INIT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] blen = 8'd0;
  logic       out_w, valid_w, done_w, busy_w, seed_err_w;
  logic [3:0] state_w;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  m_state = 4'b0001;
  logic        m_err = 1'b0;
  logic [31:0] bits_sr = 32'd0;
  int          nbits_got = 0;
  logic        first_out = 1'b0;
  logic [14:0] first15 = 15'd0;

  lfsr_prbs_gen dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .seed_i     (seed),
    .load_i     (load),
    .start_i    (start),
    .stop_i     (stop),
    .mode_i     (mode),
    .burst_len_i(blen),
    .out_o      (out_w),
    .valid_o    (valid_w),
    .done_o     (done_w),
    .busy_o     (busy_w),
    .seed_err_o (seed_err_w),
    .state_o    (state_w)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_next(input logic [3:0] s);
    int ones;
    ones = $countones(s & M_TAPS);
    return 4'((int'(s) * 2 + (ones % 2)) % 16);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    rst = 1'b0;
    m_state = M_INIT;
    m_err = 1'b0;
    chk("rst_out", out_w, 1'b0);
    chk("rst_valid", valid_w, 1'b0);
    chk("rst_done", done_w, 1'b0);
    chk("rst_busy", busy_w, 1'b0);
    chk("rst_seed_err", seed_err_w, 1'b0);
    chk("rst_state", state_w, M_INIT);
  endtask

  task automatic do_load(input logic [3:0] s);
    seed = s; load = 1'b1;
    step();
    load = 1'b0;
    m_err = (s == 4'd0);
    m_state = (s == 4'd0) ? 4'd1 : s;
    chk("load_state", state_w, m_state);
    chk("load_seed_err", seed_err_w, m_err);
    chk("load_valid", valid_w, 1'b0);
  endtask

  // Starts a run and checks every cycle against the model.
  // In continuous mode the run ends only through stop_at.
  task automatic run_seq(input logic md, input int len, input int stop_at,
                         input bit noise, input bit ld, input logic [3:0] ld_seed);
    logic exp_o;
    logic last;
    bits_sr = 32'd0;
    nbits_got = 0;
    mode = md; blen = 8'(len); start = 1'b1;
    load = ld; seed = ld_seed;
    step();
    start = 1'b0; load = 1'b0;
    if (ld) begin
      m_err = (ld_seed == 4'd0);
      m_state = (ld_seed == 4'd0) ? 4'd1 : ld_seed;
    end
    if (!md && len == 0) begin
      chk("zero_done", done_w, 1'b1);
      chk("zero_valid", valid_w, 1'b0);
      chk("zero_busy", busy_w, 1'b0);
      chk("zero_state", state_w, m_state);
      step();
      chk("zero_done_end", done_w, 1'b0);
      chk("zero_valid_end", valid_w, 1'b0);
      return;
    end
    chk("start_busy", busy_w, 1'b1);
    chk("start_valid", valid_w, 1'b0);
    chk("start_done", done_w, 1'b0);
    chk("start_state", state_w, m_state);
    for (int i = 1; i <= len + stop_at + 2; i++) begin
      if (i == stop_at) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_valid", valid_w, 1'b0);
        chk("stop_busy", busy_w, 1'b0);
        chk("stop_done", done_w, 1'b0);
        chk("stop_state", state_w, m_state);
        step();
        chk("stop_done_after", done_w, 1'b0);
        chk("stop_valid_after", valid_w, 1'b0);
        return;
      end
      if (noise) begin
        load = 1'($urandom); start = 1'($urandom); seed = 4'($urandom);
        mode = 1'($urandom); blen = 8'($urandom);
      end
      step();
      load = 1'b0; start = 1'b0;
      exp_o = m_state[3];
      m_state = m_next(m_state);
      if (nbits_got == 0) first_out = out_w;
      bits_sr = {bits_sr[30:0], out_w};
      nbits_got++;
      last = (!md && i == len);
      chk("bit_out", out_w, exp_o);
      chk("bit_valid", valid_w, 1'b1);
      chk("bit_done", done_w, last);
      chk("bit_busy", busy_w, !last);
      chk("bit_state", state_w, m_state);
      chk("bit_seed_err", seed_err_w, m_err);
      if (last) begin
        step();
        chk("end_valid", valid_w, 1'b0);
        chk("end_done", done_w, 1'b0);
        chk("end_busy", busy_w, 1'b0);
        return;
      end
    end
    chk("run_bound", 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();

    // Burst of 8 from seed 1001.
    do_load(4'b1001);
    run_seq(1'b0, 8, 0, 1'b0, 1'b0, 4'd0);
    chk("t1_bits", bits_sr[7:0], 8'b10011010);
    chk("t1_count", nbits_got, 8);
    chk("t1_state", state_w, 4'b1111);

    // Continuous run: period 15, and the second lap repeats the first.
    do_load(4'b1001);
    run_seq(1'b1, 0, 16, 1'b0, 1'b0, 4'd0);
    chk("t2_state", state_w, 4'b1001);
    first15 = bits_sr[14:0];
    run_seq(1'b1, 0, 16, 1'b0, 1'b0, 4'd0);
    chk("t2_repeat", bits_sr[14:0], first15);
    chk("t2_state2", state_w, 4'b1001);

    // Zero-seed protection.
    do_load(4'b0000);
    chk("t3_state", state_w, 4'b0001);
    chk("t3_err", seed_err_w, 1'b1);
    do_load(4'b0110);
    chk("t3_err_clr", seed_err_w, 1'b0);

    // Stop on the 3rd RUN cycle.
    do_load(4'b1001);
    run_seq(1'b0, 8, 3, 1'b0, 1'b0, 4'd0);
    chk("t4_count", nbits_got, 2);

    // Stop wins over the last burst bit.
    run_seq(1'b0, 4, 4, 1'b0, 1'b0, 4'd0);
    chk("t4_last_count", nbits_got, 3);

    // Reset mid-burst, then an empty burst.
    mode = 1'b0; blen = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    do_reset();
    step();
    chk("t5_no_done", done_w, 1'b0);
    chk("t5_no_valid", valid_w, 1'b0);
    chk("t5_no_busy", busy_w, 1'b0);
    run_seq(1'b0, 0, 0, 1'b0, 1'b0, 4'd0);

    // Load and start together, then random load/start noise during RUN.
    run_seq(1'b0, 12, 0, 1'b1, 1'b1, 4'b1001);
    chk("t6_first", first_out, 1'b1);
    chk("t6_count", nbits_got, 12);

    // Long continuous run; the counter wraps without ending the run.
    run_seq(1'b1, 0, 301, 1'b1, 1'b0, 4'd0);
    chk("wrap_count", nbits_got, 300);

    // Randomised runs.
    for (int k = 0; k < 10; k++) begin
      logic       r_md;
      int         r_len;
      int         r_stop;
      logic [3:0] r_seed;
      r_md = 1'($urandom);
      r_len = int'($urandom_range(0, 20));
      r_seed = 4'($urandom);
      if (r_md) r_stop = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 2) == 0) r_stop = int'($urandom_range(1, 21));
      else r_stop = 0;
      run_seq(r_md, r_len, r_stop, 1'($urandom), 1'($urandom), r_seed);
      if ($urandom_range(0, 3) == 0) do_load(r_seed ^ 4'b0101);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
